// File: rtl/dsi_pkg.sv
// Shared DSI definitions: data types, packetizer states, header ECC
// and the payload CRC-16 step used by the line packetizer.
package dsi_pkg;

    localparam logic [5:0]  DT_RGB565 = 6'h0E;
    localparam logic [5:0]  DT_RGB888 = 6'h3E;
    localparam logic [15:0] CRC_INIT  = 16'hFFFF;
    localparam logic [15:0] CRC_POLY  = 16'h8408;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_CRC
    } pkt_state_e;

    function automatic logic [5:0] dsi_ecc(input logic [23:0] d);
        logic [5:0] e;
        e[0] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[10]
             ^ d[11] ^ d[13] ^ d[16] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
        e[1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10]
             ^ d[12] ^ d[14] ^ d[17] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
        e[2] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[11]
             ^ d[12] ^ d[15] ^ d[18] ^ d[20] ^ d[21] ^ d[22];
        e[3] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[13]
             ^ d[14] ^ d[15] ^ d[19] ^ d[20] ^ d[21] ^ d[23];
        e[4] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[16]
             ^ d[17] ^ d[18] ^ d[19] ^ d[20] ^ d[22] ^ d[23];
        e[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16]
             ^ d[17] ^ d[18] ^ d[19] ^ d[21] ^ d[22] ^ d[23];
        return e;
    endfunction

    // Bit 0 of the word is the first bit on the wire.
    function automatic logic [15:0] dsi_crc16_step32(
        input logic [15:0] crc,
        input logic [31:0] data
    );
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 32; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_POLY;
            else                c = c >> 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/pixel_line_packetizer.sv
// Wraps one video line from the pixel FIFO into a DSI long packet
// (header+ECC, payload words, CRC-16) on a 32-bit valid/ready stream.
module pixel_line_packetizer
    import dsi_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        line_request,
    input  logic [15:0] line_bytes,
    input  logic [5:0]  data_type,
    input  logic [1:0]  virtual_channel,
    output logic        pix_fifo_read,
    input  logic [31:0] pix_fifo_data,
    input  logic        pix_fifo_empty,
    output logic [31:0] out_data,
    output logic [3:0]  out_keep,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready,
    output logic        busy,
    output logic        fifo_stall,
    output logic        aborted
);

    pkt_state_e  state_q, state_d;
    logic [13:0] rem_q, rem_d;
    logic [15:0] crc_q, crc_d;
    logic [31:0] hold_q, hold_d;
    logic        hold_vld_q, hold_vld_d;
    logic        inflight_q, inflight_d;
    logic [31:0] out_data_q, out_data_d;
    logic [3:0]  out_keep_q, out_keep_d;
    logic        out_valid_q, out_valid_d;
    logic        out_last_q, out_last_d;
    logic        aborted_q, aborted_d;

    logic        accept, avail, take, send_crc, rd;
    logic [31:0] word;
    logic [23:0] hdr;
    logic [13:0] occ;
    logic        unused_lb;

    assign unused_lb = ^line_bytes[1:0];
    assign accept    = out_valid_q && out_ready;
    assign avail     = hold_vld_q || inflight_q;
    assign word      = hold_vld_q ? hold_q : pix_fifo_data;
    assign hdr       = {line_bytes[15:2], 2'b00, virtual_channel, data_type};
    assign occ       = {13'd0, hold_vld_q} + {13'd0, inflight_q};

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        crc_d       = crc_q;
        hold_d      = hold_q;
        hold_vld_d  = hold_vld_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        aborted_d   = 1'b0;
        take        = 1'b0;
        send_crc    = 1'b0;
        rd          = 1'b0;
        if (state_q != ST_IDLE && !enable) begin
            state_d     = ST_IDLE;
            rem_d       = '0;
            hold_vld_d  = 1'b0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            aborted_d   = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (enable && line_request) begin
                        state_d     = ST_HEADER;
                        rem_d       = line_bytes[15:2];
                        crc_d       = CRC_INIT;
                        out_data_d  = {2'b00, dsi_ecc(hdr), hdr};
                        out_keep_d  = 4'hF;
                        out_valid_d = 1'b1;
                        out_last_d  = 1'b0;
                        // first read overlaps the header beat for full rate
                        rd = !pix_fifo_empty && (line_bytes[15:2] != '0);
                    end
                end
                ST_HEADER: begin
                    if (accept) begin
                        out_valid_d = 1'b0;
                        if (rem_q == '0) begin
                            send_crc = 1'b1;
                        end else begin
                            state_d = ST_PAYLOAD;
                            take    = avail;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (accept) begin
                        out_valid_d = 1'b0;
                        crc_d = dsi_crc16_step32(crc_q, out_data_q);
                        if (rem_q == '0) send_crc = 1'b1;
                        else             take     = avail;
                    end else if (!out_valid_q) begin
                        take = avail && (rem_q != '0);
                    end
                end
                ST_CRC: begin
                    if (accept) begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            if (send_crc) begin
                state_d     = ST_CRC;
                out_data_d  = {16'h0000, crc_d};
                out_keep_d  = 4'b0011;
                out_valid_d = 1'b1;
                out_last_d  = 1'b1;
            end
            if (take) begin
                out_data_d  = word;
                out_keep_d  = 4'hF;
                out_valid_d = 1'b1;
                out_last_d  = 1'b0;
                rem_d       = rem_q - 14'd1;
            end
            // a new read may only land where the hold register is free
            if (state_q != ST_IDLE) begin
                rd = !pix_fifo_empty && (rem_q > occ) && (!avail || take);
            end
            if (take && hold_vld_q) hold_vld_d = 1'b0;
            if (inflight_q && (hold_vld_q || !take)) begin
                hold_d     = pix_fifo_data;
                hold_vld_d = 1'b1;
            end
        end
        inflight_d = rd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            crc_q       <= CRC_INIT;
            hold_q      <= '0;
            hold_vld_q  <= 1'b0;
            inflight_q  <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            crc_q       <= crc_d;
            hold_q      <= hold_d;
            hold_vld_q  <= hold_vld_d;
            inflight_q  <= inflight_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            aborted_q   <= aborted_d;
        end
    end

    assign pix_fifo_read = rd;
    assign out_data      = out_data_q;
    assign out_keep      = out_keep_q;
    assign out_valid     = out_valid_q;
    assign out_last      = out_last_q;
    assign aborted       = aborted_q;
    assign busy          = (state_q != ST_IDLE);
    assign fifo_stall    = (state_q == ST_PAYLOAD) && !out_valid_q;

endmodule

// File: tb/tb_pixel_line_packetizer.sv
// Directed bench for pixel_line_packetizer: FIFO model, stream
// monitor and hand-computed headers with a byte-wise CRC model.
module tb_pixel_line_packetizer;
    import dsi_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        line_request = 1'b0;
    logic [15:0] line_bytes = '0;
    logic [5:0]  data_type = '0;
    logic [1:0]  virtual_channel = '0;
    logic        pix_fifo_read;
    logic [31:0] pix_fifo_data;
    logic        pix_fifo_empty;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_valid;
    logic        out_last;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        fifo_stall;
    logic        aborted;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pixel_line_packetizer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .line_request    (line_request),
        .line_bytes      (line_bytes),
        .data_type       (data_type),
        .virtual_channel (virtual_channel),
        .pix_fifo_read   (pix_fifo_read),
        .pix_fifo_data   (pix_fifo_data),
        .pix_fifo_empty  (pix_fifo_empty),
        .out_data        (out_data),
        .out_keep        (out_keep),
        .out_valid       (out_valid),
        .out_last        (out_last),
        .out_ready       (out_ready),
        .busy            (busy),
        .fifo_stall      (fifo_stall),
        .aborted         (aborted)
    );

    // FIFO model: normal-mode read, data valid the cycle after the strobe
    logic [31:0] mem [0:1023];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          rd_count = 0;
    int          bad_reads = 0;
    logic        force_empty = 1'b0;
    logic [31:0] fifo_dout = '0;

    assign pix_fifo_empty = force_empty || (wr_ptr == rd_ptr);
    assign pix_fifo_data  = fifo_dout;

    always @(posedge clk) begin
        if (pix_fifo_read) begin
            if (pix_fifo_empty) bad_reads <= bad_reads + 1;
            fifo_dout <= mem[rd_ptr % 1024];
            rd_ptr    <= rd_ptr + 1;
            rd_count  <= rd_count + 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stream monitor, sampling mid-cycle
    logic [31:0] cap_data [0:1023];
    logic [3:0]  cap_keep [0:1023];
    logic        cap_last [0:1023];
    int          cap_cyc  [0:1023];
    int          cap_n = 0;
    int          pkts = 0;
    int          stall_cnt = 0;
    int          abort_cnt = 0;
    int          stall_viol = 0;
    logic        pv = 1'b0;
    logic        pr = 1'b0;
    logic        pl = 1'b0;
    logic [31:0] pd = '0;
    logic [3:0]  pk = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (pv && !pr && (!out_valid || out_data !== pd ||
                              out_keep !== pk || out_last !== pl))
                stall_viol <= stall_viol + 1;
            if (out_valid && out_ready) begin
                cap_data[cap_n] <= out_data;
                cap_keep[cap_n] <= out_keep;
                cap_last[cap_n] <= out_last;
                cap_cyc[cap_n]  <= cyc;
                cap_n <= cap_n + 1;
                if (out_last) pkts <= pkts + 1;
            end
            if (fifo_stall) stall_cnt <= stall_cnt + 1;
            if (aborted) abort_cnt <= abort_cnt + 1;
            pv <= out_valid;
            pr <= out_ready;
            pd <= out_data;
            pk <= out_keep;
            pl <= out_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        mem[wr_ptr % 1024] = w;
        wr_ptr++;
    endtask

    task automatic req(input logic [15:0] lb, input logic [5:0] dt,
                       input logic [1:0] vc);
        line_bytes      = lb;
        data_type       = dt;
        virtual_channel = vc;
        line_request    = 1'b1;
        tick();
        line_request    = 1'b0;
    endtask

    task automatic wait_pkts(input int target, input int budget);
        int n;
        n = 0;
        while (pkts < target && n < budget) begin
            tick();
            n++;
        end
        chk("pkt_timeout", {31'd0, pkts >= target}, 32'd1);
        tick();
    endtask

    function automatic logic [15:0] crc_model(input logic [31:0] ws[$]);
        logic [15:0] c;
        logic [7:0]  b;
        c = 16'hFFFF;
        foreach (ws[k]) begin
            for (int j = 0; j < 4; j++) begin
                b = ws[k][8*j +: 8];
                c = c ^ {8'h00, b};
                for (int t = 0; t < 8; t++)
                    c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
            end
        end
        return c;
    endfunction

    task automatic check_packet(input int base, input logic [31:0] hdr,
                                input logic [31:0] ws[$],
                                input string tag);
        int n;
        n = ws.size();
        chk({tag, "_hdr"}, cap_data[base], hdr);
        chk({tag, "_hdr_keep"}, {28'd0, cap_keep[base]}, 32'hF);
        for (int k = 0; k < n; k++)
            chk($sformatf("%s_w%0d", tag, k), cap_data[base+1+k], ws[k]);
        chk({tag, "_crc"}, cap_data[base+n+1], {16'h0, crc_model(ws)});
        chk({tag, "_crc_keep_last"},
            {27'd0, cap_last[base+n+1], cap_keep[base+n+1]},
            {27'd0, 1'b1, 4'b0011});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] q[$];
        logic [31:0] qa[$];
        logic [31:0] qb[$];
        int base, rb, pk0, sv0, sc0, ab0, n;

        // reset
        tick();
        tick();
        chk("rst_data", out_data, 32'h0);
        chk("rst_keep", {28'd0, out_keep}, 32'h0);
        chk("rst_flags",
            {26'd0, out_valid, out_last, busy, aborted, fifo_stall,
             pix_fifo_read}, 32'h0);
        rst_n = 1'b1;
        tick();

        // zero-length line: header all zero, CRC = init value
        enable = 1'b1;
        out_ready = 1'b1;
        base = cap_n;
        rb = rd_count;
        pk0 = pkts;
        q = {};
        req(16'd0, 6'h00, 2'd0);
        chk("zero_hdr_valid", {31'd0, out_valid}, 32'd1);
        chk("zero_busy", {31'd0, busy}, 32'd1);
        wait_pkts(pk0 + 1, 20);
        chk("zero_beats", cap_n - base, 2);
        check_packet(base, 32'h0000_0000, q, "zero");
        chk("zero_reads", rd_count - rb, 0);

        // full 12-byte line, RGB888
        q = {32'h04030201, 32'h08070605, 32'h0C0B0A09};
        foreach (q[k]) push(q[k]);
        base = cap_n;
        rb = rd_count;
        pk0 = pkts;
        req(16'd12, DT_RGB888, 2'd0);
        wait_pkts(pk0 + 1, 30);
        check_packet(base, 32'h08000C3E, q, "full");
        chk("full_reads", rd_count - rb, 3);
        chk("full_rate", cap_cyc[base+4] - cap_cyc[base], 4);

        // 480 bytes with random backpressure
        q = {};
        for (int k = 0; k < 120; k++) begin
            q.push_back($urandom);
            push(q[k]);
        end
        base = cap_n;
        rb = rd_count;
        pk0 = pkts;
        sv0 = stall_viol;
        out_ready = 1'b0;
        req(16'd480, DT_RGB888, 2'd0);
        n = 0;
        while (pkts < pk0 + 1 && n < 3000) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        chk("bp_timeout", {31'd0, pkts >= pk0 + 1}, 32'd1);
        out_ready = 1'b1;
        tick();
        tick();
        chk("bp_beats", cap_n - base, 122);
        check_packet(base, 32'h1001E03E, q, "bp");
        chk("bp_stable", stall_viol - sv0, 0);
        chk("bp_reads", rd_count - rb, 120);

        // FIFO empty for 5 cycles mid-line
        q = {};
        for (int k = 0; k < 10; k++) begin
            q.push_back(32'hA5000000 | k);
            push(q[k]);
        end
        base = cap_n;
        rb = rd_count;
        pk0 = pkts;
        sc0 = stall_cnt;
        req(16'd40, DT_RGB888, 2'd0);
        repeat (3) tick();
        force_empty = 1'b1;
        repeat (5) tick();
        force_empty = 1'b0;
        wait_pkts(pk0 + 1, 60);
        chk("uf_stall_cycles", stall_cnt - sc0, 5);
        chk("uf_beats", cap_n - base, 12);
        check_packet(base, 32'h0200283E, q, "uf");
        chk("uf_reads", rd_count - rb, 10);

        // abort on payload word 3 of 10
        q = {};
        for (int k = 0; k < 10; k++) begin
            q.push_back(32'h5A000000 | k);
            push(q[k]);
        end
        rb = rd_count;
        ab0 = abort_cnt;
        pk0 = pkts;
        req(16'd40, DT_RGB888, 2'd0);
        repeat (3) tick();
        chk("ab_on_word3", out_data, q[2]);
        enable = 1'b0;
        tick();
        chk("ab_valid_drop", {31'd0, out_valid}, 32'd0);
        chk("ab_pulse", {31'd0, aborted}, 32'd1);
        chk("ab_idle", {31'd0, busy}, 32'd0);
        tick();
        chk("ab_pulse_end", {31'd0, aborted}, 32'd0);
        repeat (3) tick();
        chk("ab_reads_stop", rd_count - rb, 4);
        chk("ab_once", abort_cnt - ab0, 1);
        enable = 1'b1;
        tick();
        qa = {q[4], q[5]};
        base = cap_n;
        req(16'd8, 6'h2C, 2'd1);
        chk("ab_fresh_hdr", out_data, 32'h2500086C);
        wait_pkts(pk0 + 1, 30);
        check_packet(base, 32'h2500086C, qa, "ab_next");
        wr_ptr = rd_ptr;
        tick();

        // back-to-back with an ignored mid-packet request
        qa = {32'h11111111, 32'h22222222};
        qb = {32'h33333333};
        foreach (qa[k]) push(qa[k]);
        foreach (qb[k]) push(qb[k]);
        base = cap_n;
        rb = rd_count;
        pk0 = pkts;
        req(16'd8, DT_RGB888, 2'd0);
        tick();
        line_bytes = 16'd16;
        line_request = 1'b1;
        tick();
        line_request = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        chk("b2b_busy_fall", {31'd0, busy}, 32'd0);
        req(16'd4, DT_RGB888, 2'd0);
        chk("b2b_hdr_valid", {31'd0, out_valid}, 32'd1);
        chk("b2b_hdr_data", out_data, 32'h2D00043E);
        wait_pkts(pk0 + 2, 30);
        check_packet(base, 32'h2B00083E, qa, "b2b_a");
        check_packet(base + 4, 32'h2D00043E, qb, "b2b_b");
        chk("b2b_gap", cap_cyc[base+4] - cap_cyc[base+3], 2);
        chk("b2b_beats", cap_n - base, 7);
        chk("b2b_reads", rd_count - rb, 3);

        chk("empty_reads", bad_reads, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pixel_line_packetizer.md
# pixel_line_packetizer

Downstream neighbour of the memory-to-pixel-FIFO DMA. It drains 32-bit pixel words from the pixel FIFO and wraps one video line into a MIPI DSI long packet per line request: a 4-byte header with ECC, the payload, and a 2-byte CRC. The packet leaves as a 32-bit valid/ready byte stream toward the lane distributor.

## Interface
- No parameters.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  block enable; low aborts any packet in progress.
- `line_request`  in  1  one-cycle pulse that starts one packet; only accepted in IDLE.
- `line_bytes`  in  16  payload word count (WC) in bytes; bits [1:0] are treated as 0.
- `data_type`  in  6  DSI data type, e.g. 6'h3E for RGB888.
- `virtual_channel`  in  2  DSI virtual channel.
- `pix_fifo_read`  out  1  FIFO read strobe; normal mode, data valid the next cycle.
- `pix_fifo_data`  in  32  FIFO read data; byte [7:0] is first on the wire.
- `pix_fifo_empty`  in  1  FIFO empty flag.
- `out_data`  out  32  stream data; byte [7:0] is first.
- `out_keep`  out  4  byte-valid mask.
- `out_valid`  out  1  stream valid.
- `out_last`  out  1  last word of the packet.
- `out_ready`  in  1  downstream ready.
- `busy`  out  1  state is not IDLE.
- `fifo_stall`  out  1  high in each PAYLOAD cycle where the output is empty for lack of FIFO data.
- `aborted`  out  1  one-cycle pulse when a packet is aborted.

## Operation
- FSM has four states: IDLE, HEADER, PAYLOAD, CRC.
- IDLE → HEADER on `enable && line_request`. In the same cycle, latch `line_bytes`, `data_type` and `virtual_channel`, and load the remaining word count with `line_bytes[15:2]`.
- HEADER presents `{ecc, wc[15:8], wc[7:0], vc, dt}` with keep 4'hF.
  - On accept, go to PAYLOAD, or to CRC if WC == 0.
- PAYLOAD presents FIFO words in order with keep 4'hF.
  - On each accepted word, decrement the count and update the CRC over 4 bytes, byte 0 first.
  - On the accept of the final word, go to CRC.
- CRC presents `{16'h0, crc[15:8], crc[7:0]}` with keep 4'b0011 and last = 1.
  - On accept, go to IDLE.
- CRC algorithm: CRC-16 with polynomial 0x8408 (reflected 0x1021), init 0xFFFF, LSB-first, no final XOR. This is CRC-16/MCRF4XX, check value 0x6F91. Reinitialise at the start of each packet.
- ECC: 6-bit DSI Hamming over the 24 header bits; bits [7:6] are 0.
- FIFO prefetch:
  - Keep one holding register plus an in-flight flag.
  - Issue `pix_fifo_read` only when `!pix_fifo_empty` and (remaining words − words already in flight or held) > 0.
  - Never read beyond WC.
  - Payload reads may start during HEADER.
- `enable` low in any non-IDLE state:
  - Next state is IDLE; `out_valid` drops the next cycle.
  - `aborted` pulses.
  - Held and in-flight words are discarded and the FIFO is not flushed.
  - Outstanding prefetch is cancelled.
- `line_request` outside IDLE is ignored.
- The remaining-word counter is 14 bits and never wraps. The bench must not supply WC > 65532.

## Timing
- Reset values: all outputs 0, state IDLE, CRC register 0xFFFF.
- Output is registered. `out_*` stay stable while `out_valid && !out_ready`.
- Header `out_valid` rises 1 cycle after the accepted `line_request`.
- With a non-empty FIFO and `out_ready` held high, one word is output per cycle. A packet of N payload words occupies N+2 consecutive beats, with the header beat 1 cycle after the request.
- A FIFO word read in cycle t can be presented no earlier than t+2: t+1 data capture, t+2 output register.
- `busy` falls the cycle after the CRC beat is accepted. A new `line_request` is accepted in that same cycle.
- A simultaneous accept of the final payload word and a FIFO-empty condition produces no extra read.

## Structure
- Shared package `dsi_pkg`, which holds:
  - the data-type constants (e.g. `DT_RGB888 = 6'h3E`);
  - the state enum;
  - `dsi_ecc(24b) -> 6b`;
  - `dsi_crc16_step32(crc16, data32) -> crc16`.
- No sub-module. The CRC and ECC logic stays as package functions.

## Test plan
- Header ECC: `line_bytes = 0`, dt = 0, vc = 0, FIFO empty → beats `32'h00000000` then `{16'h0, 16'hFFFF}` with last = 1 and keep 4'b0011. Zero FIFO reads.
- Full line: dt = 6'h3E, `line_bytes = 12`, FIFO preloaded with `32'h04030201`, `32'h08070605`, `32'h0C0B0A09`, `out_ready = 1` → header byte0 = 0x3E, WC = 0x000C, ECC equal to the model. Three payload words in order, then CRC equal to the MCRF4XX model. Exactly 3 reads.
- Backpressure: random `out_ready`, `line_bytes = 480` → stable outputs while stalled. Every payload word is output exactly once and the CRC matches the model.
- Underflow: FIFO empty for 5 cycles mid-line → `fifo_stall` is high for those cycles, no word is duplicated or dropped, and the CRC is correct.
- Abort: drop `enable` on payload word 3 of 10 → `aborted` pulses once, `out_valid` is 0 the next cycle, and reads stop. With `enable` restored, the next request sends a fresh header.
- Back-to-back: a second `line_request` in the cycle `busy` falls → accepted, and the header appears 1 cycle later. A `line_request` during PAYLOAD is ignored.
